// File: rtl/fifo_pkg.sv
// Shared types and constants for the parametrised synchronous FIFO.
// The status struct is intended for bench monitors and scoreboards.
package fifo_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_DEPTH  = 16;

   // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the pointer width.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_param.
interface sync_fifo_param_if
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
);

   logic                       wr;
   logic [DATA_W-1:0]          din;
   logic                       rd;
   logic [DATA_W-1:0]          dout;
   logic                       dout_valid;
   logic                       full;
   logic                       empty;
   logic                       almost_full;
   logic                       almost_empty;
   logic [cnt_w(DEPTH)-1:0]    count;
   logic                       overflow;
   logic                       underflow;
   logic                       err_clr;

   modport master (
      output wr, din, rd, err_clr,
      input  dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr, din, rd, err_clr,
      output dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
// Storage is not reset; only the read register is.
module fifo_mem #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Same-address read/write returns the old word: no write-to-read bypass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      rdata <= '0;
      else if (re)  rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: pointer/count control, level flags and
// sticky overflow/underflow errors around a fifo_mem storage array.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2
) (
   input logic               clk,
   input logic               rst,
   sync_fifo_param_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          wr_acc;
   logic          rd_acc;
   logic          dout_valid;
   logic          overflow;
   logic          underflow;

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign rd_acc = bus.rd && !empty;
   // A write into a full FIFO is accepted when a read frees a slot the same cycle.
   assign wr_acc = bus.wr && (!full || rd_acc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         dout_valid <= rd_acc;
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A new error takes priority over a coincident clear.
         if (bus.wr && !wr_acc) overflow <= 1'b1;
         else if (bus.err_clr)  overflow <= 1'b0;
         if (bus.rd && !rd_acc) underflow <= 1'b1;
         else if (bus.err_clr)  underflow <= 1'b0;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (bus.din),
      .re    (rd_acc),
      .raddr (rd_ptr),
      .rdata (bus.dout)
   );

   assign bus.dout_valid   = dout_valid;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= CW'(AF_LEVEL));
   assign bus.almost_empty = (count <= CW'(AE_LEVEL));
   assign bus.count        = count;
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=14, AE=2).
module tb_sync_fifo_param;
   import fifo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   fifo_status_t st;

   always #5 clk = ~clk;

   sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

   sync_fifo_param #(
      .DATA_W   (8),
      .DEPTH    (16),
      .AF_LEVEL (14),
      .AE_LEVEL (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c = 1'b0);
      bus.wr = w; bus.din = d; bus.rd = r; bus.err_clr = c;
      @(posedge clk);
      #1;
      bus.wr = 1'b0; bus.rd = 1'b0; bus.err_clr = 1'b0;
   endtask

   initial begin
      bus.wr = 1'b0; bus.din = '0; bus.rd = 1'b0; bus.err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cyc(0, 8'h00, 0);

      // Reset state
      st = '{full: bus.full, empty: bus.empty, almost_full: bus.almost_full,
             almost_empty: bus.almost_empty, overflow: bus.overflow, underflow: bus.underflow};
      chk("rst_status", 32'(st), 32'(6'b010100));
      chk("rst_count", bus.count, 0);
      chk("rst_dout", bus.dout, 8'h00);
      chk("rst_dv", bus.dout_valid, 0);

      // Fill 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         cyc(1, 8'(i), 0);
         chk("fill_count", bus.count, i);
         chk("fill_full", bus.full, (i == 16));
         chk("fill_af", bus.almost_full, (i >= 14));
         chk("fill_ae", bus.almost_empty, (i <= 2));
      end
      cyc(1, 8'hAA, 0);
      chk("ovf_set", bus.overflow, 1);
      chk("ovf_count", bus.count, 16);
      cyc(0, 8'h00, 0);
      chk("ovf_sticky", bus.overflow, 1);
      cyc(0, 8'h00, 0, 1);
      chk("ovf_clr", bus.overflow, 0);

      // Drain 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         cyc(0, 8'h00, 1);
         chk("drain_dout", bus.dout, i);
         chk("drain_dv", bus.dout_valid, 1);
         chk("drain_count", bus.count, 16 - i);
         chk("drain_empty", bus.empty, (i == 16));
         chk("drain_ae", bus.almost_empty, (16 - i <= 2));
      end
      cyc(0, 8'h00, 0);
      chk("idle_dv", bus.dout_valid, 0);
      chk("idle_dout_hold", bus.dout, 8'h10);
      cyc(0, 8'h00, 1);
      chk("udf_set", bus.underflow, 1);
      chk("udf_dout_hold", bus.dout, 8'h10);
      chk("udf_dv", bus.dout_valid, 0);
      chk("udf_count", bus.count, 0);
      cyc(0, 8'h00, 0, 1);
      chk("udf_clr", bus.underflow, 0);

      // Wrap-around
      for (int i = 0; i < 10; i++) cyc(1, 8'(8'h30 + i), 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 8'h00, 1);
         chk("wrap1_dout", bus.dout, 8'h30 + i);
      end
      for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0);
      chk("wrap_full", bus.full, 1);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 8'h00, 1);
         chk("wrap2_dout", bus.dout, 8'h20 + i);
      end
      chk("wrap_count", bus.count, 0);
      chk("wrap_errs", {bus.overflow, bus.underflow}, 2'b00);

      // Simultaneous wr+rd while full
      for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0);
      cyc(1, 8'h55, 1);
      chk("fullrw_dout", bus.dout, 8'h40);
      chk("fullrw_count", bus.count, 16);
      chk("fullrw_ovf", bus.overflow, 0);
      for (int i = 1; i <= 16; i++) begin
         cyc(0, 8'h00, 1);
         chk("fullrw_drain", bus.dout, (i == 16) ? 8'h55 : 8'(8'h40 + i));
      end

      // Simultaneous wr+rd while empty
      cyc(1, 8'h66, 1);
      chk("emptyrw_udf", bus.underflow, 1);
      chk("emptyrw_count", bus.count, 1);
      chk("emptyrw_dv", bus.dout_valid, 0);
      chk("emptyrw_dout", bus.dout, 8'h55);
      cyc(0, 8'h00, 1);
      chk("emptyrw_read", bus.dout, 8'h66);
      cyc(0, 8'h00, 1, 1);
      chk("clr_vs_err", bus.underflow, 1);
      cyc(0, 8'h00, 0, 1);
      chk("clr_after", bus.underflow, 0);

      // Asynchronous reset mid-cycle with 7 entries
      for (int i = 0; i < 7; i++) cyc(1, 8'(8'h70 + i), 0);
      chk("pre_rst_count", bus.count, 7);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", bus.count, 0);
      chk("arst_empty", bus.empty, 1);
      chk("arst_dout", bus.dout, 8'h00);
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(1, 8'h77, 0);
      cyc(0, 8'h00, 1);
      chk("post_rst_read", bus.dout, 8'h77);
      chk("post_rst_dv", bus.dout_valid, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
